// File: rtl/ldmx_dma_packer.sv
// Frames 32-bit event words into 64-bit DMA beats: header (event number),
// paired data words (odd tail padded), trailer (word count, tLast).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | between events; waits for packer_en && evt_valid
// HEADER  | loads the header beat once the output register is free
// BODY    | accepts words, pairs them into beats
// TRAILER | loads the trailer, then waits for it to transfer
module ldmx_dma_packer #(
  parameter logic [15:0] HDR_MAGIC = 16'hDA7A,
  parameter logic [15:0] TRL_MAGIC = 16'hE0E0
) (
  input  logic        dmaClk,
  input  logic        dmaRst,
  input  logic        packer_en,
  input  logic        evt_valid,
  input  logic [31:0] evt_data,
  input  logic        evt_last,
  output logic        evt_ready,
  output logic        dma_valid,
  output logic [63:0] dma_data,
  output logic [7:0]  dma_keep,
  output logic        dma_last,
  input  logic        dma_ready,
  output logic [31:0] evt_count
);

  typedef enum logic [1:0] {IDLE, HEADER, BODY, TRAILER} state_t;

  state_t      state, state_nxt;
  logic [31:0] evt_num;
  logic [31:0] wcnt;
  logic [31:0] lo;
  logic        have_lo;
  logic        trl_loaded;

  logic        out_free;
  logic        ld;
  logic [63:0] ld_data;
  logic [7:0]  ld_keep;
  logic        ld_last;
  logic        clr_cnt;
  logic        store_lo;
  logic        clr_lo;
  logic        wcnt_inc;
  logic        trl_set;
  logic        trl_done;

  assign out_free  = !dma_valid || dma_ready;
  // evt_num only advances on trailer transfer, so it is exactly the count of sent events
  assign evt_count = evt_num;

  always_ff @(posedge dmaClk or posedge dmaRst) begin
    if (dmaRst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    evt_ready = 1'b0;
    ld        = 1'b0;
    ld_data   = '0;
    ld_keep   = '0;
    ld_last   = 1'b0;
    clr_cnt   = 1'b0;
    store_lo  = 1'b0;
    clr_lo    = 1'b0;
    wcnt_inc  = 1'b0;
    trl_set   = 1'b0;
    trl_done  = 1'b0;
    case (state)
      IDLE: begin
        if (packer_en && evt_valid) state_nxt = HEADER;
      end
      HEADER: begin
        if (out_free) begin
          ld        = 1'b1;
          ld_data   = {HDR_MAGIC, 16'h0000, evt_num};
          ld_keep   = 8'hFF;
          clr_cnt   = 1'b1;
          state_nxt = BODY;
        end
      end
      BODY: begin
        evt_ready = out_free;
        if (evt_valid && out_free) begin
          wcnt_inc = 1'b1;
          if (!have_lo && !evt_last) begin
            store_lo = 1'b1;
          end else if (!have_lo) begin
            ld        = 1'b1;
            ld_data   = {32'h0, evt_data};
            ld_keep   = 8'h0F;
            state_nxt = TRAILER;
          end else begin
            ld      = 1'b1;
            ld_data = {evt_data, lo};
            ld_keep = 8'hFF;
            clr_lo  = 1'b1;
            if (evt_last) state_nxt = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (!trl_loaded) begin
          if (out_free) begin
            ld      = 1'b1;
            ld_data = {TRL_MAGIC, 16'h0000, wcnt};
            ld_keep = 8'hFF;
            ld_last = 1'b1;
            trl_set = 1'b1;
          end
        end else if (dma_ready) begin
          trl_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dmaClk or posedge dmaRst) begin
    if (dmaRst) begin
      dma_valid <= 1'b0;
      dma_data  <= '0;
      dma_keep  <= '0;
      dma_last  <= 1'b0;
    end else if (ld) begin
      dma_valid <= 1'b1;
      dma_data  <= ld_data;
      dma_keep  <= ld_keep;
      dma_last  <= ld_last;
    end else if (dma_ready) begin
      dma_valid <= 1'b0;
    end
  end

  always_ff @(posedge dmaClk or posedge dmaRst) begin
    if (dmaRst) begin
      wcnt       <= '0;
      have_lo    <= 1'b0;
      lo         <= '0;
      trl_loaded <= 1'b0;
      evt_num    <= '0;
    end else begin
      if (clr_cnt) begin
        wcnt <= '0;
      end else if (wcnt_inc) begin
        wcnt <= wcnt + 32'd1;
      end
      if (clr_cnt || clr_lo) begin
        have_lo <= 1'b0;
      end else if (store_lo) begin
        have_lo <= 1'b1;
      end
      if (store_lo) lo <= evt_data;
      if (trl_set) begin
        trl_loaded <= 1'b1;
      end else if (trl_done) begin
        trl_loaded <= 1'b0;
      end
      if (trl_done) evt_num <= evt_num + 32'd1;
    end
  end

endmodule

// File: tb/tb_ldmx_dma_packer.sv
// Directed bench for ldmx_dma_packer: hand-computed frames plus a small
// frame model, stall-hold monitor and asynchronous reset checks.
module tb_ldmx_dma_packer;

  logic        dmaClk = 1'b0;
  logic        dmaRst;
  logic        packer_en;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_last;
  logic        evt_ready;
  logic        dma_valid;
  logic [63:0] dma_data;
  logic [7:0]  dma_keep;
  logic        dma_last;
  logic        dma_ready;
  logic [31:0] evt_count;

  int n_vec = 0;
  int n_err = 0;

  logic [79:0] cap[$];
  logic [79:0] exp_q[$];
  logic [31:0] wbuf[0:15];
  int          wn;
  logic        bp_en = 1'b0;

  ldmx_dma_packer dut (
    .dmaClk   (dmaClk),
    .dmaRst   (dmaRst),
    .packer_en(packer_en),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .evt_last (evt_last),
    .evt_ready(evt_ready),
    .dma_valid(dma_valid),
    .dma_data (dma_data),
    .dma_keep (dma_keep),
    .dma_last (dma_last),
    .dma_ready(dma_ready),
    .evt_count(evt_count)
  );

  always #5 dmaClk = ~dmaClk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] mk(input logic [63:0] d, input logic [7:0] k, input logic l);
    return {7'b0, l, k, d};
  endfunction

  // dma_ready: all-ones, or the 1,0,0,1 stall pattern when bp_en is set
  initial begin
    int ph = 0;
    dma_ready = 1'b1;
    forever begin
      @(posedge dmaClk);
      #1;
      if (bp_en) begin
        dma_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        dma_ready = 1'b1;
      end
    end
  end

  // capture transfers; check hold-while-stalled and no input acceptance while stalled
  initial begin
    logic [79:0] prev_beat;
    logic        prev_stall = 1'b0;
    forever begin
      @(negedge dmaClk);
      if (dmaRst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {7'b0, dma_valid, dma_keep, dma_data},
                            {7'b0, 1'b1, prev_beat[71:0]});
        if (dma_valid && !dma_ready) chk("stall_no_accept", {79'b0, evt_ready}, 80'd0);
        if (dma_valid && dma_ready) cap.push_back(mk(dma_data, dma_keep, dma_last));
        prev_stall = dma_valid && !dma_ready;
        prev_beat  = mk(dma_data, dma_keep, dma_last);
      end
    end
  end

  task automatic model_event(input logic [31:0] e);
    exp_q.push_back(mk({16'hDA7A, 16'h0000, e}, 8'hFF, 1'b0));
    for (int i = 0; i < wn; i += 2) begin
      if (i + 1 < wn) exp_q.push_back(mk({wbuf[i+1], wbuf[i]}, 8'hFF, 1'b0));
      else            exp_q.push_back(mk({32'h0, wbuf[i]}, 8'h0F, 1'b0));
    end
    exp_q.push_back(mk({16'hE0E0, 16'h0000, 32'(wn)}, 8'hFF, 1'b1));
  endtask

  // presents one word and returns the number of cycles waited for evt_ready
  task automatic send_word(input int i, output int waited);
    int k;
    evt_valid = 1'b1;
    evt_data  = wbuf[i];
    evt_last  = (i == wn - 1);
    for (k = 0; k < 100; k++) begin
      @(negedge dmaClk);
      if (evt_ready) break;
    end
    waited = k;
    if (k == 100) chk("accept_timeout", 80'd0, 80'd1);
    @(posedge dmaClk);
    #1;
    evt_valid = 1'b0;
    evt_last  = 1'b0;
  endtask

  task automatic send_event(input bit drop_en, output int first_wait);
    int w;
    for (int i = 0; i < wn; i++) begin
      send_word(i, w);
      if (i == 0) begin
        first_wait = w;
        if (drop_en) packer_en = 1'b0;
      end
    end
  endtask

  task automatic wait_frame();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge dmaClk);
      if (cap.size() >= exp_q.size()) break;
    end
    if (k == 300) chk("frame_timeout", 80'd0, 80'd1);
    repeat (2) @(negedge dmaClk);
  endtask

  task automatic compare_frame(input string tag);
    chk({tag, "_nbeats"}, 80'(cap.size()), 80'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), cap[i], exp_q[i]);
    cap.delete();
    exp_q.delete();
  endtask

  task automatic idle_blocked(input string tag);
    evt_valid = 1'b1;
    evt_data  = 32'hDEAD;
    evt_last  = 1'b1;
    repeat (8) begin
      @(negedge dmaClk);
      chk({tag, "_ready"}, {79'b0, evt_ready}, 80'd0);
      chk({tag, "_valid"}, {79'b0, dma_valid}, 80'd0);
    end
    @(posedge dmaClk);
    #1;
    evt_valid = 1'b0;
    evt_last  = 1'b0;
    chk({tag, "_nbeats"}, 80'(cap.size()), 80'd0);
  endtask

  initial begin
    int fw;
    dmaRst    = 1'b1;
    packer_en = 1'b1;
    evt_valid = 1'b0;
    evt_data  = '0;
    evt_last  = 1'b0;
    repeat (3) @(negedge dmaClk);
    dmaRst = 1'b0;
    @(negedge dmaClk);
    chk("rst_valid", {79'b0, dma_valid}, 80'd0);
    chk("rst_ready", {79'b0, evt_ready}, 80'd0);
    chk("rst_count", 80'(evt_count), 80'd0);
    chk("rst_beat", mk(dma_data, dma_keep, dma_last), 80'd0);
    @(posedge dmaClk);
    #1;

    // single-word event, event number 0; first word accepted 2 cycles after evt_valid
    wn = 1; wbuf[0] = 32'h5;
    model_event(32'd0);
    send_event(1'b0, fw);
    chk("hdr_latency", 80'(fw), 80'd2);
    wait_frame();
    chk("single_keep0f", 80'(exp_q[1][71:64]), 80'h0F);
    compare_frame("single");

    // four-word event, hand-computed
    wn = 4; wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
    exp_q.push_back(mk(64'hDA7A_0000_0000_0001, 8'hFF, 1'b0));
    exp_q.push_back(mk(64'h0000_0022_0000_0011, 8'hFF, 1'b0));
    exp_q.push_back(mk(64'h0000_0044_0000_0033, 8'hFF, 1'b0));
    exp_q.push_back(mk(64'hE0E0_0000_0000_0004, 8'hFF, 1'b1));
    send_event(1'b0, fw);
    wait_frame();
    compare_frame("four");
    chk("count_after_four", 80'(evt_count), 80'd2);

    // odd three-word event, hand-computed
    wn = 3; wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    exp_q.push_back(mk(64'hDA7A_0000_0000_0002, 8'hFF, 1'b0));
    exp_q.push_back(mk(64'h0000_000B_0000_000A, 8'hFF, 1'b0));
    exp_q.push_back(mk(64'h0000_0000_0000_000C, 8'h0F, 1'b0));
    exp_q.push_back(mk(64'hE0E0_0000_0000_0003, 8'hFF, 1'b1));
    send_event(1'b0, fw);
    wait_frame();
    compare_frame("odd");

    // six-word event under 1,0,0,1 backpressure
    wn = 6;
    for (int i = 0; i < 6; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    model_event(32'd3);
    bp_en = 1'b1;
    send_event(1'b0, fw);
    wait_frame();
    bp_en = 1'b0;
    compare_frame("bp");
    chk("count_after_bp", 80'(evt_count), 80'd4);

    // disabled in IDLE: nothing starts
    packer_en = 1'b0;
    idle_blocked("dis_idle");

    // disable mid-event: the frame completes, then the block stays idle
    packer_en = 1'b1;
    wn = 4;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h1234_5670 + 32'(i);
    model_event(32'd4);
    send_event(1'b1, fw);
    wait_frame();
    compare_frame("drop");
    chk("count_after_drop", 80'(evt_count), 80'd5);
    idle_blocked("dis_after");

    // asynchronous reset mid-event, after header and one data beat
    packer_en = 1'b1;
    wn = 4;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h9990 + 32'(i);
    send_word(0, fw);
    send_word(1, fw);
    begin
      int k;
      for (k = 0; k < 50; k++) begin
        @(negedge dmaClk);
        if (cap.size() >= 2) break;
      end
      if (k == 50) chk("rst_pre_timeout", 80'd0, 80'd1);
    end
    evt_valid = 1'b1;
    evt_data  = wbuf[2];
    #2;
    dmaRst = 1'b1;
    #1;
    chk("arst_valid", {79'b0, dma_valid}, 80'd0);
    chk("arst_beat", mk(dma_data, dma_keep, dma_last), 80'd0);
    chk("arst_ready", {79'b0, evt_ready}, 80'd0);
    chk("arst_count", 80'(evt_count), 80'd0);
    evt_valid = 1'b0;
    repeat (2) @(negedge dmaClk);
    dmaRst = 1'b0;
    cap.delete();
    @(posedge dmaClk);
    #1;
    wn = 2; wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    model_event(32'd0);
    send_event(1'b0, fw);
    wait_frame();
    compare_frame("post_rst");
    chk("count_post_rst", 80'(evt_count), 80'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ldmx_dma_packer.md
# ldmx_dma_packer

Packs the 32-bit event-word stream produced by the DAQ event builder into the 64-bit inbound DMA stream (`dmaIbMaster_*`) of the DPM. It frames every event with a 64-bit header beat carrying a running event number and a 64-bit trailer beat carrying the event's word count, pads odd-length events, and asserts tLast on the trailer. It sits between the event builder's readout port and the RCE DMA0 inbound channel, entirely in the DMA clock domain.

## Interface
- `HDR_MAGIC`, 16'hDA7A: bits [63:48] of the header beat.
- `TRL_MAGIC`, 16'hE0E0: bits [63:48] of the trailer beat.

- `dmaClk` in 1: DMA clock; the only clock.
- `dmaRst` in 1: reset, asynchronous, active-high.
- `packer_en` in 1: when low, no new event is started; an event in progress completes.
- `evt_valid` in 1: input word valid.
- `evt_data` in 32: input word.
- `evt_last` in 1: marks the final word of an event.
- `evt_ready` out 1: input word accepted when `evt_valid && evt_ready`.
- `dma_valid` out 1: output beat valid (drives `dmaIbMaster_tValid`).
- `dma_data` out 64: output beat.
- `dma_keep` out 8: byte enables (drives tKeep; tStrb is tied to `dma_keep` at top level).
- `dma_last` out 1: end of frame (drives tLast).
- `dma_ready` in 1: from `dmaIbSlave_tReady`.
- `evt_count` out 32: number of events fully transmitted (trailer accepted).

## Operation
- Output stage is one register set {`dma_valid`, `dma_data`, `dma_keep`, `dma_last`}. A beat transfers on `dma_valid && dma_ready`. While `dma_valid && !dma_ready`, all output fields hold stable. The register may be reloaded in the same cycle its beat transfers ("free" = `!dma_valid || dma_ready`).
- States: IDLE, HEADER, BODY, TRAILER.
- IDLE: `evt_ready`=0. If `packer_en && evt_valid`, go to HEADER. No input word is consumed.
- HEADER: when the output is free, load {`HDR_MAGIC`, 16'h0000, `evt_num`} with keep 8'hFF and last 0, then go to BODY. Clear the word counter `wcnt` and `have_lo`.
- BODY: `evt_ready` = output free. On each accepted word, `wcnt` increments (32-bit, wraps mod 2^32).
  - `have_lo`=0 and not last: store the word in `lo` and set `have_lo`=1. No beat is loaded.
  - `have_lo`=0 and last: load {32'h0, word} with keep 8'h0F, then go to TRAILER.
  - `have_lo`=1: load {word, `lo`} with keep 8'hFF and clear `have_lo`. If last, go to TRAILER.
  - The first word of a pair always occupies bits [31:0].
- TRAILER: `evt_ready`=0. When the output is free, load {`TRL_MAGIC`, 16'h0000, `wcnt`} with keep 8'hFF and last 1.
- After the trailer is loaded: when the trailer beat transfers, `evt_num` and `evt_count` increment (both wrap). Then return to IDLE. A new header may not be loaded before the trailer has transferred.
- `evt_num` is the number of the current event, starting at 0. `evt_count` equals `evt_num` whenever the block is in IDLE.
- `packer_en` is sampled only in IDLE.
- Reset (asynchronous, any state, mid-event included) clears to: state IDLE, `dma_valid`=0, `dma_data`=0, `dma_keep`=0, `dma_last`=0, `evt_ready`=0, `evt_count`=0, `evt_num`=0, `wcnt`=0, `have_lo`=0. A partially sent frame is abandoned; the downstream side is reset together with this block.

## Timing
- From `evt_valid` seen in IDLE (cycle 0): header valid at cycle 2 (1 cycle IDLE→HEADER, 1 cycle to load), provided the output is free.
- Input word to output beat: 1 cycle for the second word of a pair or for an odd last word.
- Last beat to trailer valid: 1 cycle after the last data beat transfers. With `dma_ready` held at 1, the trailer follows the last data beat on consecutive cycles.
- Sustained throughput with `dma_ready`=1: one 32-bit word per cycle in, one 64-bit beat every 2 cycles out.
- Frame length in beats = 2 + ceil(N/2) for an N-word event.
- `evt_count` updates the cycle after the trailer transfer.

## Test plan
- Single event, 4 words 0x11,0x22,0x33,0x44, `dma_ready`=1 → beats: {DA7A,0,0x00000000}; {0x22,0x11} keep FF; {0x44,0x33} keep FF; {E0E0,0,0x00000004} last=1. Afterwards `evt_count`=1.
- Odd event, 3 words 0xA,0xB,0xC → data beats {0xB,0xA} keep FF, then {0,0xC} keep 0F; trailer `wcnt`=3.
- Single-word event 0x5 → 3 beats total; the middle beat is keep 0F; the next event's header carries `evt_num`=1.
- Backpressure: `dma_ready` toggles with pattern 1,0,0,1 during a 6-word event → beats and their fields are unchanged while stalled; no input word is accepted while the output is stalled and occupied; the output sequence is identical to the unstalled case.
- `packer_en`=0 in IDLE with `evt_valid`=1 → no beats and `evt_ready`=0. Deasserting `packer_en` mid-event → the event completes including its trailer, and then the block stays in IDLE.
- Assert `dmaRst` after the header and one data beat → all outputs 0 within the reset cycle (asynchronous). The next event's header carries `evt_num`=0.
